mod_mul_seq: RTL and testbench



---
 rtl/mod_mul_seq.sv | 134 +++++++++++++
 tb/tb_mod_mul_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_seq.sv
// Bit-serial interleaved double-and-add modular multiplier, R = A*B mod P_MOD.
// Define MOD_MUL_RADIX4_EN to retire two multiplier bits per RUN cycle.
module mod_mul_seq #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P_MOD =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
`ifdef MOD_MUL_RADIX4_EN
    localparam logic [CW-1:0] CNT_STEP = CW'(2);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
`else
    localparam logic [CW-1:0] CNT_STEP = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(0);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step;
    logic [CW-1:0]    cnt_lo;

    // Both operands are < P_MOD, so every intermediate fits in WIDTH+1 bits.
    function automatic logic [WIDTH-1:0] dbl_add(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] a,
        input logic             bit_i
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] u;
        t = {acc, 1'b0};
        if (t >= {1'b0, P_MOD}) t = t - {1'b0, P_MOD};
        u = bit_i ? t + {1'b0, a} : t;
        if (u >= {1'b0, P_MOD}) u = u - {1'b0, P_MOD};
        return u[WIDTH-1:0];
    endfunction

    always_comb begin
        cnt_lo = cnt_q - CW'(1);
`ifdef MOD_MUL_RADIX4_EN
        step = dbl_add(dbl_add(acc_q, a_q, b_q[cnt_q]), a_q, b_q[cnt_lo]);
`else
        step = dbl_add(acc_q, a_q, b_q[cnt_q]);
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A < 2^WIDTH < 2*P_MOD, so a single conditional subtract reduces it.
                if (a_q >= P_MOD) a_d = a_q - P_MOD;
                acc_d   = '0;
                cnt_d   = CNT_INIT;
                state_d = RUN;
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    r_d     = step;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Scoreboard bench for mod_mul_seq: expected products are queued at issue
// and compared, with latency, when done pulses.
module tb_mod_mul_seq;

    localparam logic [255:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
`ifdef MOD_MUL_RADIX4_EN
    localparam int LAT = 129;
`else
    localparam int LAT = 257;
`endif
    localparam int LIMIT = LAT + 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] r;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    mod_mul_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (a),
        .B    (b),
        .busy (busy),
        .done (done),
        .R    (r)
    );

    typedef struct {
        logic [255:0] exp;
        int           t0;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   edge_cnt = 0;
    int   n_done = 0;
    int   n_acc = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [255:0] ref_mul(input logic [255:0] x,
                                             input logic [255:0] y);
        logic [511:0] pr;
        logic [511:0] m;
        pr = {256'b0, x} * {256'b0, y};
        m  = pr % {256'b0, P};
        return m[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (done) begin
            exp_t e;
            n_done++;
            chk("busy_at_done", 256'(busy), 256'(0));
            if (sb.size() == 0) begin
                chk("spurious_done", 256'(done), 256'(0));
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_R"}, r, e.exp);
                chk({e.tag, "_lat"}, 256'(edge_cnt - e.t0), 256'(LAT));
            end
        end
    end

    task automatic issue(input string tag, input logic [255:0] x,
                         input logic [255:0] y);
        exp_t e;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        e.exp = ref_mul(x, y);
        e.t0  = edge_cnt;
        e.tag = tag;
        sb.push_back(e);
        n_acc++;
    endtask

    task automatic wait_idle(input bit noisy);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (noisy && busy) begin
                a = rnd256();
                b = rnd256();
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end while ((busy || sb.size() != 0) && n < LIMIT);
        start = 1'b0;
        if (n >= LIMIT) begin
            chk("timeout", 256'(n), 256'(LAT));
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_R", r, 256'(0));
        rst = 1'b0;

        issue("t1_3x5", 256'd3, 256'd5);
        chk("t1_busy", 256'(busy), 256'(1));
        wait_idle(0);
        chk("t1_idle", 256'(busy), 256'(0));

        issue("t2_pm1sq", P - 1, P - 1);
        wait_idle(0);
        issue("t2_pm1x2", P - 1, 256'd2);
        wait_idle(0);

        issue("t3_pp5x2", P + 5, 256'd2);
        wait_idle(0);
        issue("t3_max", {256{1'b1}}, 256'd1);
        wait_idle(0);
        chk("t3_max_val", r, 256'h1000003D0);

        issue("t4_a0", 256'd0, rnd256());
        wait_idle(0);
        issue("t4_b0", rnd256(), 256'd0);
        wait_idle(0);
        issue("t4_b2b", 256'd7, 256'd6);
        wait_idle(0);
        chk("t4_42", r, 256'd42);

        issue("t5_ign", rnd256(), rnd256());
        a = 256'd1;
        b = 256'd1;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle(0);

        issue("t5_abort", rnd256(), rnd256());
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        n_acc--;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(done), 256'(0));
        chk("abort_R", r, 256'(0));
        repeat (LAT + 10) @(posedge clk);
        #2;
        issue("t5_fresh", rnd256(), rnd256());
        wait_idle(0);

        a = 256'd5;
        b = 256'd5;
        start = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_wins_busy", 256'(busy), 256'(0));
        @(posedge clk);
        #2;
        chk("rst_wins_busy2", 256'(busy), 256'(0));

        for (int i = 0; i < 60; i++) begin
            issue("t6_rand", rnd256(), rnd256());
            wait_idle(1);
        end

        repeat (4) @(posedge clk);
        #2;
        chk("done_count", 256'(n_done), 256'(n_acc));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
